// File: rtl/ahb_lite_rr_master.sv
// Round-robin AHB-Lite master: shares one AHB-Lite slave among NUM_REQ command
// ports, one NONSEQ single transfer at a time, with stall timeout and abort.
module ahb_lite_rr_master #(
    parameter int NUM_REQ     = 2,
    parameter int ID_W        = (NUM_REQ > 2) ? 2 : 1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [3*NUM_REQ-1:0]  req_size,
    input  logic [32*NUM_REQ-1:0] req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic [31:0]           HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [31:0]           HWDATA,
    input  logic                  HREADY,
    input  logic [31:0]           HRDATA,
    input  logic                  HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [7:0] WAIT_LAST     = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_REJ} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cmd_id;
    logic            cmd_write;
    logic [31:0]     cmd_wdata;
    logic [7:0]      wait_cnt;

    logic [ID_W-1:0] winner;
    logic            win_found;
    logic [2:0]      sel_size;
    logic [31:0]     sel_addr;
    logic            sel_illegal;

    // Search starts just after the last granted requester and wraps.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                winner    = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign sel_size    = req_size[3*int'(winner) +: 3];
    assign sel_addr    = req_addr[32*int'(winner) +: 32];
    assign sel_illegal = (sel_size > 3'd2) ||
                         (sel_size == 3'd1 && sel_addr[0]) ||
                         (sel_size == 3'd2 && sel_addr[1:0] != 2'b00);

    // NOTE: req_ready gets a default before the conditional write so no path leaves it unassigned (no latch).
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && win_found) req_ready[winner] = 1'b1;
    end

    assign busy = (state != S_IDLE);

    // NOTE: non-blocking assignments throughout, so every register sees pre-edge values of the others.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= S_IDLE;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            cmd_id      <= '0;
            cmd_write   <= 1'b0;
            cmd_wdata   <= '0;
            wait_cnt    <= '0;
            HADDR       <= '0;
            HTRANS      <= HTRANS_IDLE;
            HWRITE      <= 1'b0;
            HSIZE       <= '0;
            HWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        rr_ptr    <= winner;
                        cmd_id    <= winner;
                        cmd_write <= req_write[winner];
                        cmd_wdata <= req_wdata[32*int'(winner) +: 32];
                        if (sel_illegal) begin
                            state <= S_REJ;
                        end else begin
                            state    <= S_ADDR;
                            HTRANS   <= HTRANS_NONSEQ;
                            HADDR    <= sel_addr;
                            HWRITE   <= req_write[winner];
                            HSIZE    <= sel_size;
                            wait_cnt <= '0;
                        end
                    end
                end
                S_REJ: begin
                    state       <= S_IDLE;
                    rsp_valid   <= 1'b1;
                    rsp_id      <= cmd_id;
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b0;
                end
                S_ADDR: begin
                    if (HREADY) begin
                        state    <= S_DATA;
                        HTRANS   <= HTRANS_IDLE;
                        HWDATA   <= cmd_wdata;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= S_IDLE;
                        HTRANS      <= HTRANS_IDLE;
                        rsp_valid   <= 1'b1;
                        rsp_id      <= cmd_id;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    // HRESP is only meaningful on the HREADY-high cycle.
                    if (HREADY) begin
                        state       <= S_IDLE;
                        rsp_valid   <= 1'b1;
                        rsp_id      <= cmd_id;
                        rsp_rdata   <= cmd_write ? 32'h0 : HRDATA;
                        rsp_err     <= HRESP;
                        rsp_timeout <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= S_IDLE;
                        rsp_valid   <= 1'b1;
                        rsp_id      <= cmd_id;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
